imem_boot_loader: RTL and testbench

- Sits directly upstream of the pipelined MIPS core.
- Receives a program image as a byte stream over a valid/ready handshake, packs it into 32-bit words, and writes them into instruction memory through its write port.
- Holds the core's PC reset asserted until the whole image is written, then releases it.
- Replaces simulation-only $readmemh image loading with a synthesizable load path.

---
 rtl/imem_boot_loader.sv | 194 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Purpose:
//   Streams a program image into the MIPS core's instruction memory over a
//   byte-wide valid/ready handshake. The image starts with a big-endian 16-bit
//   word count N. The header is followed by N big-endian 32-bit words. Each
//   word is written to instruction memory through a single-cycle write strobe.
//   The core's PC reset stays asserted until the last word has been written.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   pc_rst     in   1       synchronous active-low reset of this block
//   in_data    in   8       image byte
//   in_valid   in   1       in_data carries a byte
//   in_ready   out  1       loader takes a byte this cycle
//   load_start in   1       pulse, restarts a load from RUN or ERR
//   im_we      out  1       instruction memory write enable
//   im_addr    out  ADDR_W  instruction memory word address
//   im_wdata   out  32      instruction memory write data
//   core_rst   out  1       active-high reset to the pipeline PC
//   load_done  out  1       image fully loaded, core running
//   load_err   out  1       header asked for more words than memory holds
// ---------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int INST_MEM_LENGTH = 1024,
  parameter int ADDR_W          = 10
) (
  input  logic              clk,
  input  logic              pc_rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_start,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);

  // Loader phases: two header bytes, word assembly, the write cycle, and the
  // two resting states that only load_start (or pc_rst) can leave.
  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    WR,
    RUN,
    ERR
  } loaderState_t;

  // Memory depth widened to 17 bits so it compares cleanly against the
  // 16-bit word count, even when the depth is 65536.
  localparam logic [16:0] LP_MEM_LEN = 17'(INST_MEM_LENGTH);

  loaderState_t      r_state;
  loaderState_t      w_stateNext;
  logic [15:0]       r_wordCount;
  logic [ADDR_W:0]   r_idx;
  logic [1:0]        r_byteCnt;
  logic [23:0]       r_byteBuf;

  logic              w_xfer;
  logic [15:0]       w_headerCount;
  logic [16:0]       w_idxPlusOne;
  logic              w_lastWord;
  logic [31:0]       w_shiftedWord;
  logic              w_nextAccepts;

  // A byte moves only when both sides agree. in_ready is a registered copy of
  // "the state we are in accepts bytes", so it is used directly as the
  // accept qualifier. in_ready is also 0 in the first cycle after reset.
  assign w_xfer = in_valid & in_ready;

  // Full word count as it will look once the second header byte is latched.
  assign w_headerCount = {r_wordCount[15:8], in_data};

  // The 17-bit increment lets idx+1 reach the full memory depth without
  // wrapping before it is compared against N.
  assign w_idxPlusOne = 17'(r_idx) + 17'd1;
  assign w_lastWord   = (w_idxPlusOne == {1'b0, r_wordCount});

  // The word being completed: the three buffered bytes followed by the byte
  // arriving now. The first byte received ends up in bits 31:24.
  assign w_shiftedWord = {r_byteBuf, in_data};

  // Next-state decode. Every output is registered from this decision, so each
  // output changes on the same edge as the state it reflects.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      HDR0: begin
        if (w_xfer) begin
          w_stateNext = HDR1;
        end
      end
      HDR1: begin
        if (w_xfer) begin
          if ({1'b0, w_headerCount} > LP_MEM_LEN) begin
            w_stateNext = ERR;
          end else if (w_headerCount == 16'd0) begin
            w_stateNext = RUN;
          end else begin
            w_stateNext = DATA;
          end
        end
      end
      DATA: begin
        if (w_xfer && (r_byteCnt == 2'd3)) begin
          w_stateNext = WR;
        end
      end
      WR: begin
        w_stateNext = w_lastWord ? RUN : DATA;
      end
      RUN, ERR: begin
        if (load_start) begin
          w_stateNext = HDR0;
        end
      end
      default: begin
        w_stateNext = HDR0;
      end
    endcase
  end

  // Bytes are accepted only in the header and data-gathering states. This
  // keeps in_ready low during the write cycle and while resting in RUN or ERR.
  assign w_nextAccepts = (w_stateNext == HDR0) ||
                         (w_stateNext == HDR1) ||
                         (w_stateNext == DATA);

  // The FSM register plus all datapath registers and registered outputs.
  // The write strobe is launched on the edge that takes in the fourth byte,
  // so im_we, im_addr and im_wdata are valid during the WR cycle itself.
  // im_addr and im_wdata are only loaded at that point and hold otherwise.
  always_ff @(posedge clk) begin
    if (!pc_rst) begin
      r_state     <= HDR0;
      r_wordCount <= 16'd0;
      r_idx       <= '0;
      r_byteCnt   <= 2'd0;
      r_byteBuf   <= 24'd0;
      in_ready    <= 1'b0;
      im_we       <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= 32'd0;
      core_rst    <= 1'b1;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      in_ready  <= w_nextAccepts;
      core_rst  <= (w_stateNext != RUN);
      load_done <= (w_stateNext == RUN);
      load_err  <= (w_stateNext == ERR);
      im_we     <= 1'b0;

      case (r_state)
        HDR0: begin
          if (w_xfer) begin
            r_wordCount[15:8] <= in_data;
          end
        end
        HDR1: begin
          if (w_xfer) begin
            r_wordCount[7:0] <= in_data;
            r_idx            <= '0;
            r_byteCnt        <= 2'd0;
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_byteBuf <= w_shiftedWord[23:0];
            r_byteCnt <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              im_we    <= 1'b1;
              im_addr  <= r_idx[ADDR_W-1:0];
              im_wdata <= w_shiftedWord;
            end
          end
        end
        WR: begin
          r_idx <= w_idxPlusOne[ADDR_W:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed bench for imem_boot_loader. A cycle-by-cycle vector table covers
// the following:
//   - reset
//   - a single-word load
//   - an empty image
//   - an oversize header and recovery
//   - the exact-depth header
//   - reset overriding a live handshake
// Hand-written sequences then cover the following:
//   - a gapped stream
//   - reset in the middle of a word
//   - restart from RUN
// Every memory write the DUT issues is logged and compared against the
// expected address/data list.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

  logic        clk;
  logic        pcRst;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic        loadStart;
  logic        imWe;
  logic [9:0]  imAddr;
  logic [31:0] imWdata;
  logic        coreRst;
  logic        loadDone;
  logic        loadErr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rstN;
    logic        valid;
    logic [7:0]  data;
    logic        start;
    logic        expReady;
    logic        expWe;
    logic [9:0]  expAddr;
    logic [31:0] expWdata;
    logic        expCoreRst;
    logic        expDone;
    logic        expErr;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  streamQ[$];
  logic [9:0]  wrAddr[$];
  logic [31:0] wrData[$];
  logic [9:0]  expAddrQ[$];
  logic [31:0] expDataQ[$];

  imem_boot_loader #(
    .INST_MEM_LENGTH(1024),
    .ADDR_W(10)
  ) dut (
    .clk       (clk),
    .pc_rst    (pcRst),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .load_start(loadStart),
    .im_we     (imWe),
    .im_addr   (imAddr),
    .im_wdata  (imWdata),
    .core_rst  (coreRst),
    .load_done (loadDone),
    .load_err  (loadErr)
  );

  // 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behaves like the instruction memory write port. It records every write
  // the DUT commits on a rising edge.
  always @(posedge clk) begin
    if (imWe) begin
      wrAddr.push_back(imAddr);
      wrData.push_back(imWdata);
    end
  end

  // Hard stop if anything wedges despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports it if it does not match.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Appends one cycle of inputs and the outputs expected after that edge.
  task automatic addVec(input logic rstN, input logic valid, input logic [7:0] data,
                        input logic start, input logic ready, input logic we,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        input logic core, input logic done, input logic err);
    vec_t v;
    v.rstN = rstN; v.valid = valid; v.data = data; v.start = start;
    v.expReady = ready; v.expWe = we; v.expAddr = addr; v.expWdata = wdata;
    v.expCoreRst = core; v.expDone = done; v.expErr = err;
    vecs.push_back(v);
  endtask

  // Drives one vector on the falling edge. It then checks all outputs just
  // after the following rising edge.
  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    pcRst     = v.rstN;
    inValid   = v.valid;
    inData    = v.data;
    loadStart = v.start;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d in_ready", idx), 32'(inReady), 32'(v.expReady));
    checkOutput($sformatf("vec%0d im_we", idx), 32'(imWe), 32'(v.expWe));
    checkOutput($sformatf("vec%0d im_addr", idx), 32'(imAddr), 32'(v.expAddr));
    checkOutput($sformatf("vec%0d im_wdata", idx), imWdata, v.expWdata);
    checkOutput($sformatf("vec%0d core_rst", idx), 32'(coreRst), 32'(v.expCoreRst));
    checkOutput($sformatf("vec%0d load_done", idx), 32'(loadDone), 32'(v.expDone));
    checkOutput($sformatf("vec%0d load_err", idx), 32'(loadErr), 32'(v.expErr));
  endtask

  // Offers streamQ byte by byte. A byte counts as taken only when it was
  // offered while in_ready was high in the cycle before the rising edge. When
  // toggle is set, in_valid alternates every cycle, and junk data is driven
  // on the idle cycles.
  task automatic runStream(input string name, input bit toggle, input int budget);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    while (k < streamQ.size() && cyc < budget) begin
      @(negedge clk);
      inValid = toggle ? ((cyc % 2) == 0) : 1'b1;
      inData  = inValid ? streamQ[k] : 8'hEE;
      if (inValid && inReady) begin
        k++;
      end
      cyc++;
    end
    @(negedge clk);
    inValid = 1'b0;
    inData  = 8'h00;
    checkOutput({name, " bytes consumed"}, 32'(k), 32'(streamQ.size()));
  endtask

  // Waits a bounded number of cycles for load_done.
  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while (!loadDone && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " load_done"}, 32'(loadDone), 32'd1);
    checkOutput({name, " core_rst"}, 32'(coreRst), 32'd0);
  endtask

  // Compares the logged memory writes against the expected list.
  task automatic checkWrites(input string name);
    checkOutput({name, " write count"}, 32'(wrAddr.size()), 32'(expAddrQ.size()));
    for (int i = 0; i < expAddrQ.size() && i < wrAddr.size(); i++) begin
      checkOutput($sformatf("%s write%0d addr", name, i), 32'(wrAddr[i]), 32'(expAddrQ[i]));
      checkOutput($sformatf("%s write%0d data", name, i), wrData[i], expDataQ[i]);
    end
  endtask

  // Pulses load_start for one cycle.
  task automatic pulseStart();
    @(negedge clk);
    loadStart = 1'b1;
    @(negedge clk);
    loadStart = 1'b0;
  endtask

  initial begin
    pcRst     = 1'b0;
    inValid   = 1'b0;
    inData    = 8'h00;
    loadStart = 1'b0;

    // Columns: rstN valid data start | ready we addr wdata core done err
    // Reset, then image 00 01 12345678 with in_valid held high. A load_start
    // during DATA is ignored.
    addVec(0, 0, 8'h00, 0,  0, 0, 10'd0, 32'h00000000, 1, 0, 0);
    addVec(1, 1, 8'h00, 0,  1, 0, 10'd0, 32'h00000000, 1, 0, 0);
    addVec(1, 1, 8'h00, 0,  1, 0, 10'd0, 32'h00000000, 1, 0, 0);
    addVec(1, 1, 8'h01, 0,  1, 0, 10'd0, 32'h00000000, 1, 0, 0);
    addVec(1, 1, 8'h12, 1,  1, 0, 10'd0, 32'h00000000, 1, 0, 0);
    addVec(1, 1, 8'h34, 0,  1, 0, 10'd0, 32'h00000000, 1, 0, 0);
    addVec(1, 1, 8'h56, 0,  1, 0, 10'd0, 32'h00000000, 1, 0, 0);
    addVec(1, 1, 8'h78, 0,  0, 1, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 0, 8'h00, 0,  0, 0, 10'd0, 32'h12345678, 0, 1, 0);
    addVec(1, 0, 8'h00, 0,  0, 0, 10'd0, 32'h12345678, 0, 1, 0);
    // Restart, then an empty image. RUN is entered on the second header edge.
    addVec(1, 0, 8'h00, 1,  1, 0, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 1, 8'h00, 0,  1, 0, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 1, 8'h00, 0,  0, 0, 10'd0, 32'h12345678, 0, 1, 0);
    // Restart, then header 04 01 (1025 words): ERR, which ignores further bytes.
    addVec(1, 0, 8'h00, 1,  1, 0, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 1, 8'h04, 0,  1, 0, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 1, 8'h01, 0,  0, 0, 10'd0, 32'h12345678, 1, 0, 1);
    addVec(1, 1, 8'h00, 0,  0, 0, 10'd0, 32'h12345678, 1, 0, 1);
    // Recover from ERR with load_start. A load_start in HDR1 is ignored.
    addVec(1, 0, 8'h00, 1,  1, 0, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 1, 8'h00, 0,  1, 0, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 1, 8'h01, 1,  1, 0, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 1, 8'hAA, 0,  1, 0, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 1, 8'hBB, 0,  1, 0, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 1, 8'hCC, 0,  1, 0, 10'd0, 32'h12345678, 1, 0, 0);
    addVec(1, 1, 8'hDD, 0,  0, 1, 10'd0, 32'hAABBCCDD, 1, 0, 0);
    addVec(1, 0, 8'h00, 0,  0, 0, 10'd0, 32'hAABBCCDD, 0, 1, 0);
    // Header 04 00 (exactly 1024 words) is legal. Reset then overrides a live
    // handshake.
    addVec(1, 0, 8'h00, 1,  1, 0, 10'd0, 32'hAABBCCDD, 1, 0, 0);
    addVec(1, 1, 8'h04, 0,  1, 0, 10'd0, 32'hAABBCCDD, 1, 0, 0);
    addVec(1, 1, 8'h00, 0,  1, 0, 10'd0, 32'hAABBCCDD, 1, 0, 0);
    addVec(0, 1, 8'h55, 0,  0, 0, 10'd0, 32'h00000000, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i, vecs[i]);
    end

    // N=3 with in_valid toggling every cycle. Bytes offered during the write
    // cycles must not be swallowed, or the words would come out shifted.
    wrAddr.delete(); wrData.delete();
    @(negedge clk);
    pcRst   = 1'b1;
    inValid = 1'b0;
    streamQ = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    runStream("toggle", 1'b1, 200);
    waitDone("toggle", 20);
    expAddrQ = '{10'd0, 10'd1, 10'd2};
    expDataQ = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    checkWrites("toggle");

    // Reset after 2 of the 4 bytes of word 1. Word 0 has already been written.
    wrAddr.delete(); wrData.delete();
    pulseStart();
    streamQ = '{8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    runStream("partial", 1'b0, 100);
    pcRst = 1'b0;
    @(negedge clk);
    checkOutput("midreset in_ready", 32'(inReady), 32'd0);
    checkOutput("midreset im_we", 32'(imWe), 32'd0);
    checkOutput("midreset im_addr", 32'(imAddr), 32'd0);
    checkOutput("midreset im_wdata", imWdata, 32'd0);
    checkOutput("midreset core_rst", 32'(coreRst), 32'd1);
    checkOutput("midreset load_done", 32'(loadDone), 32'd0);
    checkOutput("midreset load_err", 32'(loadErr), 32'd0);
    expAddrQ = '{10'd0};
    expDataQ = '{32'hA1A2A3A4};
    checkWrites("partial");

    // Reload N=2. No stale bytes may leak from the abandoned word.
    wrAddr.delete(); wrData.delete();
    pcRst = 1'b1;
    streamQ = '{8'h00, 8'h02, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    runStream("reload", 1'b0, 100);
    waitDone("reload", 20);
    expAddrQ = '{10'd0, 10'd1};
    expDataQ = '{32'hC1C2C3C4, 32'hD1D2D3D4};
    checkWrites("reload");

    // Restart from RUN. core_rst rises again on the next cycle, and a new
    // image overwrites address 0.
    wrAddr.delete(); wrData.delete();
    pulseStart();
    checkOutput("restart core_rst", 32'(coreRst), 32'd1);
    checkOutput("restart in_ready", 32'(inReady), 32'd1);
    checkOutput("restart load_done", 32'(loadDone), 32'd0);
    streamQ = '{8'h00, 8'h01, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
    runStream("restart", 1'b0, 100);
    waitDone("restart", 20);
    expAddrQ = '{10'd0};
    expDataQ = '{32'h0F1E2D3C};
    checkWrites("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
